window_gen_3x3: RTL

- Converts a raster-order pixel stream (one pixel per clock when valid) into a 3x3 neighbourhood window.
- Uses two line buffers plus a 3x3 register array.
- Its outputs pixel0..pixel8 connect directly to the same-named inputs of Median_Finder_9inputs_8bits, making it the producing end of that interface.
- Sits between the pixel source and the median stage in the median-filter datapath.

---
 rtl/median_filter_pkg.sv | 22 ++
 rtl/line_buffer_ram.sv | 31 +++
 rtl/window_gen_3x3.sv | 129 ++++++++++++
 3 files changed

// File: rtl/median_filter_pkg.sv
// rtl/median_filter_pkg.sv - shared constants and types for the median-filter datapath
// Contents: default pixel width, 3x3 window index constants (row-major,
// TL = oldest/top-left, BR = newest/bottom-right), 9-element window type.
package median_filter_pkg;

  localparam int DEFAULT_DATA_W = 8;

  localparam int WIN_TL = 0;
  localparam int WIN_TM = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MM = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BM = 7;
  localparam int WIN_BR = 8;

  localparam int WIN_SIZE = 9;

  typedef logic [DEFAULT_DATA_W-1:0] window_t [WIN_SIZE];

endpackage

// File: rtl/line_buffer_ram.sv
// rtl/line_buffer_ram.sv - single-clock line buffer, combinational read, synchronous write
// Ports:
//   clk   : write clock (rising edge)
//   we    : write enable
//   addr  : shared read/write address
//   wdata : write data
//   rdata : contents at addr before this edge's write (read-before-write)
module line_buffer_ram #(
  parameter int DEPTH  = 640,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Contents are intentionally not reset; the window generator gates
  // its output by row so stale data never reaches a valid window.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - raster pixel stream to 3x3 neighbourhood window
// Ports:
//   clk, rst_n        : clock and asynchronous active-low reset
//   pix_in            : incoming pixel, raster order
//   pix_valid_in      : pix_in accepted this edge (no backpressure)
//   sof_in            : start of frame, marks pixel (0,0); qualified by pix_valid_in
//   pixel0..pixel8    : window, row-major, pixel0 top-left, pixel8 bottom-right
//   win_valid         : window outputs valid (1 cycle after bottom-right pixel)
//   frame_done        : one-cycle pulse after the last pixel of a frame
module window_gen_3x3
  import median_filter_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid_in,
  input  logic              sof_in,
  output logic [DATA_W-1:0] pixel0,
  output logic [DATA_W-1:0] pixel1,
  output logic [DATA_W-1:0] pixel2,
  output logic [DATA_W-1:0] pixel3,
  output logic [DATA_W-1:0] pixel4,
  output logic [DATA_W-1:0] pixel5,
  output logic [DATA_W-1:0] pixel6,
  output logic [DATA_W-1:0] pixel7,
  output logic [DATA_W-1:0] pixel8,
  output logic              win_valid,
  output logic              frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]  col, col_eff;
  logic [ROW_W-1:0]  row, row_eff;
  logic [DATA_W-1:0] top, mid;
  logic [DATA_W-1:0] win      [WIN_SIZE];
  logic [DATA_W-1:0] win_next [WIN_SIZE];
  logic [DATA_W-1:0] out_q    [WIN_SIZE];
  logic              accept, emit, line_end, frame_end;

  assign accept = pix_valid_in;

  // sof_in forces the current pixel to (0,0) regardless of the counters.
  assign col_eff = sof_in ? '0 : col;
  assign row_eff = sof_in ? '0 : row;

  assign line_end  = (col_eff == COL_LAST);
  assign frame_end = line_end && (row_eff == ROW_LAST);

  // Only full windows with the bottom-right pixel at r>=2, c>=2 are
  // emitted; this also hides line-wrap windows and stale line-buffer data.
  assign emit = accept && (row_eff >= ROW_W'(2)) && (col_eff >= COL_W'(2));

  // lb_a holds line r-1; its old contents cascade into lb_b (line r-2).
  line_buffer_ram #(.DEPTH(IMG_W), .DATA_W(DATA_W)) lb_a (
    .clk   (clk),
    .we    (accept),
    .addr  (col_eff),
    .wdata (pix_in),
    .rdata (mid)
  );

  line_buffer_ram #(.DEPTH(IMG_W), .DATA_W(DATA_W)) lb_b (
    .clk   (clk),
    .we    (accept),
    .addr  (col_eff),
    .wdata (mid),
    .rdata (top)
  );

  always_comb begin
    win_next = win;
    win_next[WIN_TL] = win[WIN_TM];
    win_next[WIN_TM] = win[WIN_TR];
    win_next[WIN_TR] = top;
    win_next[WIN_ML] = win[WIN_MM];
    win_next[WIN_MM] = win[WIN_MR];
    win_next[WIN_MR] = mid;
    win_next[WIN_BL] = win[WIN_BM];
    win_next[WIN_BM] = win[WIN_BR];
    win_next[WIN_BR] = pix_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      win        <= '{default: '0};
      out_q      <= '{default: '0};
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= emit;
      frame_done <= accept && frame_end;
      if (accept) begin
        win <= win_next;
        // Outputs load only with valid windows so they hold otherwise.
        if (emit) begin
          out_q <= win_next;
        end
        if (line_end) begin
          col <= '0;
          row <= (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
        end else begin
          col <= col_eff + 1'b1;
          row <= row_eff;
        end
      end
    end
  end

  assign pixel0 = out_q[WIN_TL];
  assign pixel1 = out_q[WIN_TM];
  assign pixel2 = out_q[WIN_TR];
  assign pixel3 = out_q[WIN_ML];
  assign pixel4 = out_q[WIN_MM];
  assign pixel5 = out_q[WIN_MR];
  assign pixel6 = out_q[WIN_BL];
  assign pixel7 = out_q[WIN_BM];
  assign pixel8 = out_q[WIN_BR];

endmodule
